// File: rtl/memory_arbiter_if.sv
// Request/grant bus for both requesters plus the memory-side port of memory_arbiter.
// The lock0/lock1 signals exist only when ARB_LOCK_EN is defined.
interface memory_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_LOCK_EN
   logic              lock0;
   logic              lock1;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we
   );
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we
   );
`else
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we
   );
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we
   );
`endif
endinterface

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter with burst cap in front of a single-port synchronous memory.
// Define ARB_LOCK_EN to add lock0/lock1 (owner keeps the memory for atomic sequences).
module memory_arbiter #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   memory_arbiter_if.slave  bus
);
   localparam int unsigned    CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_next_cnt;
   logic [CNT_W-1:0]  w_base;
   logic              r_last_owner;
   logic              w_next_last;
   logic              w_issue;
   logic              w_sel;
   logic              w_other_req;
   logic              w_sel_lock;
   logic              w_same_owner;
   logic              w_cap;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   logic              r_gnt0;
   logic              r_gnt1;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_we;
   logic              r_rd_pend;
   logic              r_rd_port;

`ifdef ARB_LOCK_EN
   assign w_sel_lock = w_sel ? bus.lock1 : bus.lock0;
`else
   assign w_sel_lock = 1'b0;
`endif

   assign w_we    = w_sel ? bus.we1    : bus.we0;
   assign w_addr  = w_sel ? bus.addr1  : bus.addr0;
   assign w_wdata = w_sel ? bus.wdata1 : bus.wdata0;

   // Pick the port issued at this edge; ownership moves after the edge.
   always_comb begin
      w_issue      = bus.req0 | bus.req1;
      w_sel        = 1'b0;
      w_other_req  = 1'b0;
      w_same_owner = 1'b0;
      w_base       = '0;
      w_cap        = 1'b0;
      w_next_state = S_IDLE;
      w_next_cnt   = '0;
      w_next_last  = r_last_owner;

      case (r_state)
         S_OWN0:  w_sel = ~bus.req0;
         S_OWN1:  w_sel = bus.req1;
         default: w_sel = (bus.req0 & bus.req1) ? ~r_last_owner : bus.req1;
      endcase

      w_other_req  = w_sel ? bus.req0 : bus.req1;
      w_same_owner = (r_state == S_OWN0 && !w_sel) || (r_state == S_OWN1 && w_sel);
      w_base       = w_same_owner ? r_cnt : '0;
      w_cap        = w_issue && w_other_req && !w_sel_lock && (w_base == CNT_CAP);

      if (w_issue) begin
         if (w_cap) w_next_state = w_sel ? S_OWN0 : S_OWN1;
         else       w_next_state = w_sel ? S_OWN1 : S_OWN0;
      end

      // Count saturates so a long lock cannot wrap it back below the cap.
      if (w_issue && w_other_req && !w_cap)
         w_next_cnt = (w_base == CNT_CAP) ? w_base : w_base + CNT_W'(1);

      if (r_state == S_OWN0 && w_next_state != S_OWN0) w_next_last = 1'b0;
      if (r_state == S_OWN1 && w_next_state != S_OWN1) w_next_last = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_last_owner <= 1'b1;
      end else begin
         r_state      <= w_next_state;
         r_cnt        <= w_next_cnt;
         r_last_owner <= w_next_last;
      end
   end

   // Issue stage and read-return stage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_rvalid0   <= 1'b0;
         r_rvalid1   <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_rd_pend   <= 1'b0;
         r_rd_port   <= 1'b0;
      end else begin
         r_gnt0    <= w_issue & ~w_sel;
         r_gnt1    <= w_issue & w_sel;
         r_mem_we  <= w_issue & w_we;
         r_rd_pend <= w_issue & ~w_we;
         r_rd_port <= w_sel;
         if (w_issue)         r_mem_addr  <= w_addr;
         if (w_issue && w_we) r_mem_wdata <= w_wdata;
         r_rvalid0 <= r_rd_pend & ~r_rd_port;
         r_rvalid1 <= r_rd_pend & r_rd_port;
         if (r_rd_pend && !r_rd_port) r_rdata0 <= bus.mem_rdata;
         if (r_rd_pend &&  r_rd_port) r_rdata1 <= bus.mem_rdata;
      end
   end

   assign bus.gnt0      = r_gnt0;
   assign bus.gnt1      = r_gnt1;
   assign bus.rvalid0   = r_rvalid0;
   assign bus.rvalid1   = r_rvalid1;
   assign bus.rdata0    = r_rdata0;
   assign bus.rdata1    = r_rdata1;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_we    = r_mem_we;
endmodule
